// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and access-size decode for the LSU word adapter.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] MEM_WIDTH_WORD = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StWr0,
    StWr1,
    StDone
  } lsu_state_t;

  // Access size in bytes; encoding 2'b11 is illegal and faulted by the caller.
  function automatic logic [2:0] lsu_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: extracts/extends load data from a two-word window and merges store bytes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] buf0_i,
  input  logic [31:0] buf1_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] wr0_o,
  output logic [31:0] wr1_o
);

  logic [63:0] window;
  logic [63:0] shifted;
  logic [63:0] wdata_sh;
  logic [63:0] bit_mask;
  logic [63:0] merged;
  logic [7:0]  lane_mask;
  logic [7:0]  byte_mask;

  always_comb begin
    window  = {buf1_i, buf0_i};
    shifted = window >> {off_i, 3'b000};

    case (size_i)
      3'd1:    load_o = unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      3'd2:    load_o = unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_o = shifted[31:0];
    endcase

    case (size_i)
      3'd1:    lane_mask = 8'b0000_0001;
      3'd2:    lane_mask = 8'b0000_0011;
      default: lane_mask = 8'b0000_1111;
    endcase
    byte_mask = lane_mask << off_i;

    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end

    // Lanes 4..7 belong to the following word and feed the second write.
    wdata_sh = {32'b0, wdata_i} << {off_i, 3'b000};
    merged   = (window & ~bit_mask) | (wdata_sh & bit_mask);
    wr0_o    = merged[31:0];
    wr1_o    = merged[63:32];
  end

endmodule

// File: rtl/lsu_word_adapter.sv
// Byte-addressed load/store adapter over a word-only memory using read-modify-write.
// Word-crossing accesses are split when LSU_MISALIGN_SPLIT_EN is defined, faulted otherwise.
module lsu_word_adapter
  import lsu_pkg::*;
#(
  parameter int unsigned N  = 12,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_fault,
  output logic [31:0]   mem_addr,
  output logic [2:0]    mem_width,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (DW != 32) begin : g_dw_check
    $fatal(1, "lsu_word_adapter: DW must be 32");
  end

  lsu_state_t  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [N-1:0] w0_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] buf0_q;
  logic [31:0] buf1;
  logic [N-1:0] mem_word_q, mem_word_d;

  logic        accept;
  logic [1:0]  off_in;
  logic [2:0]  size_in;
  logic        cross_in;
  logic [N-1:0] w0_in;
  logic        bad_f3;
  logic        fault_in;
  logic [31:0] load_data;
  logic [31:0] wr0_data;
  logic [31:0] wr1_data;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        cross_q;
  logic [31:0] buf1_q;
  assign buf1 = buf1_q;
`else
  assign buf1 = '0;
`endif

  always_comb begin
    accept   = req_valid & req_ready;
    off_in   = req_addr[1:0];
    size_in  = lsu_size(req_funct3[1:0]);
    cross_in = ({1'b0, off_in} + size_in) > 3'd4;
    w0_in    = req_addr[N+1:2];
    bad_f3   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_SPLIT_EN
    // No wrap-around from the last word to word 0.
    fault_in = bad_f3 || (|req_addr[31:N+2]) || (cross_in && (&w0_in));
`else
    fault_in = bad_f3 || (|req_addr[31:N+2]) || cross_in;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (fault_in) begin
            state_d = StDone;
          end else if (req_we && (req_funct3 == F3_W) && (off_in == 2'b00)) begin
            state_d = StWr0;
          end else begin
            state_d = StRd0;
          end
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      StRd0:  state_d = cross_q ? StRd1 : (we_q ? StWr0 : StDone);
      StRd1:  state_d = we_q ? StWr0 : StDone;
      StWr0:  state_d = cross_q ? StWr1 : StDone;
      StWr1:  state_d = StDone;
`else
      StRd0:  state_d = we_q ? StWr0 : StDone;
      StWr0:  state_d = StDone;
`endif
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_word_d = mem_word_q;
    case (state_q)
      StRd0, StWr0: mem_word_d = w0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
      StRd1, StWr1: mem_word_d = w0_q + {{(N-1){1'b0}}, 1'b1};
`endif
      default:      mem_word_d = mem_word_q;
    endcase

    req_ready  = (state_q == StIdle) && !rst;
    resp_valid = (state_q == StDone) && !rst;
    resp_fault = resp_valid && fault_q;
    resp_rdata = (resp_valid && !fault_q && !we_q) ? load_data : 32'b0;
    mem_addr   = {{(32-N){1'b0}}, mem_word_d};
    mem_width  = MEM_WIDTH_WORD;
    mem_we     = ((state_q == StWr0) || (state_q == StWr1)) && !rst;
    mem_wdata  = '0;
    if (state_q == StWr0) begin
      mem_wdata = wr0_data;
    end else if (state_q == StWr1) begin
      mem_wdata = wr1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_word_q <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      w0_q       <= '0;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
      buf0_q     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q    <= 1'b0;
      buf1_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_word_q <= mem_word_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= off_in;
        w0_q    <= w0_in;
        wdata_q <= req_wdata;
        fault_q <= fault_in;
`ifdef LSU_MISALIGN_SPLIT_EN
        cross_q <= cross_in;
`endif
      end
      if (state_q == StRd0) begin
        buf0_q <= mem_rdata;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_q == StRd1) begin
        buf1_q <= mem_rdata;
      end
`endif
    end
  end

  lsu_align u_align (
    .off_i      (off_q),
    .size_i     (lsu_size(f3_q[1:0])),
    .unsigned_i (f3_q[2]),
    .buf0_i     (buf0_q),
    .buf1_i     (buf1),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .wr0_o      (wr0_data),
    .wr1_o      (wr1_data)
  );

endmodule

// File: tb/tb_lsu_word_adapter.sv
// Scoreboard bench for lsu_word_adapter with a behavioural word memory.
module tb_lsu_word_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [2:0]  mem_width;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_word_adapter #(
    .N  (12),
    .DW (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_width  (mem_width),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] mem [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_a = '0;
  logic [31:0] poke_d = '0;
  int          n_writes = 0;

  assign mem_rdata = mem[mem_addr[11:0]];

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wdata;
      n_writes <= n_writes + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          wr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge ending DONE.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] e_rdata, input logic e_fault,
                         input int e_lat, input int e_wr);
    exp_t e;
    exp_t got;
    int   lat;
    int   wr_base;
    e.rdata = e_rdata;
    e.fault = e_fault;
    e.lat   = e_lat;
    e.wr    = e_wr;
    sb_q.push_back(e);
    check_eq({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    wr_base    = n_writes;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = sb_q.pop_front();
    check_eq({tag, "_lat"}, lat, got.lat);
    check_eq({tag, "_rdata"}, resp_rdata, got.rdata);
    check_eq({tag, "_fault"}, {31'b0, resp_fault}, {31'b0, got.fault});
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    check_eq({tag, "_writes"}, n_writes - wr_base, got.wr);
  endtask

  task automatic quiet_window(input string tag, input int wr_base, input int e_wr);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) pulses++;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_no_resp"}, pulses, 32'd0);
    check_eq({tag, "_writes"}, n_writes - wr_base, e_wr);
  endtask

  initial begin
    int wr_base;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, req_ready}, 32'd0);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    check_eq("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("mem_width", {29'b0, mem_width}, 32'd2);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", {31'b0, req_ready}, 32'd1);

    poke(12'd5, 32'h8899AABB);
    poke(12'd4095, 32'h0BADF00D);

    run_req("lb",   1'b0, 3'b000, 32'h16, 32'h0, 32'hFFFFFF99, 1'b0, 2, 0);
    run_req("lhu",  1'b0, 3'b101, 32'h15, 32'h0, 32'h000099AA, 1'b0, 2, 0);
    run_req("lw",   1'b0, 3'b010, 32'h14, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
    run_req("lh",   1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
    run_req("sb",   1'b1, 3'b000, 32'h17, 32'hFFFFFF11, 32'h0, 1'b0, 3, 1);
    check_eq("sb_mem", mem[5], 32'h1199AABB);
    run_req("lbu",  1'b0, 3'b100, 32'h17, 32'h0, 32'h00000011, 1'b0, 2, 0);
    run_req("sh",   1'b1, 3'b001, 32'h14, 32'hFFFF1234, 32'h0, 1'b0, 3, 1);
    check_eq("sh_mem", mem[5], 32'h11991234);
    run_req("lb_pos", 1'b0, 3'b000, 32'h14, 32'h0, 32'h00000034, 1'b0, 2, 0);
    run_req("sw",   1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1);
    check_eq("sw_mem", mem[8], 32'hCAFEF00D);

    run_req("f3_011", 1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("f3_110", 1'b0, 3'b110, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("st_f3_100", 1'b1, 3'b100, 32'h14, 32'h55, 32'h0, 1'b1, 1, 0);
    check_eq("st_f3_100_mem", mem[5], 32'h11991234);
    run_req("oob",  1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("last_cross", 1'b0, 3'b001, 32'h3FFF, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("last_lw", 1'b0, 3'b010, 32'h3FFC, 32'h0, 32'h0BADF00D, 1'b0, 2, 0);

    poke(12'd1, 32'h44332211);
    poke(12'd2, 32'h88776655);
`ifdef LSU_MISALIGN_SPLIT_EN
    run_req("lw_x", 1'b0, 3'b010, 32'h07, 32'h0, 32'h77665544, 1'b0, 3, 0);
    run_req("lh_x", 1'b0, 3'b001, 32'h07, 32'h0, 32'h00005544, 1'b0, 3, 0);
    run_req("sw_x", 1'b1, 3'b010, 32'h06, 32'hDEADBEEF, 32'h0, 1'b0, 5, 2);
    check_eq("sw_x_w1", mem[1], 32'hBEEF2211);
    check_eq("sw_x_w2", mem[2], 32'h8877DEAD);

    // Reset while the second half of a split store is on the bus.
    poke(12'd1, 32'h44332211);
    poke(12'd2, 32'h88776655);
    wr_base    = n_writes;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h06;
    req_wdata  = 32'hA5A5C3C3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("wr1_mem_we", {31'b0, mem_we}, 32'd1);
    check_eq("wr1_mem_addr", mem_addr, 32'd2);
    rst = 1'b1;
    #1;
    check_eq("wr1_rst_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("wr1_rst_ready", {31'b0, req_ready}, 32'd1);
    quiet_window("wr1_rst", wr_base, 1);
    check_eq("wr1_rst_w1", mem[1], 32'hC3C32211);
    check_eq("wr1_rst_w2", mem[2], 32'h88776655);
`else
    run_req("lw_x", 1'b0, 3'b010, 32'h07, 32'h0, 32'h0, 1'b1, 1, 0);
    run_req("sw_x", 1'b1, 3'b010, 32'h06, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0);
    check_eq("sw_x_w1", mem[1], 32'h44332211);
    check_eq("sw_x_w2", mem[2], 32'h88776655);
    run_req("sh_06", 1'b1, 3'b001, 32'h06, 32'h0000BEEF, 32'h0, 1'b0, 3, 1);
    check_eq("sh_06_mem", mem[1], 32'hBEEF2211);
`endif

    // Reset during the read phase of a sub-word store: nothing written, no response.
    wr_base    = n_writes;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h17;
    req_wdata  = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rd0_rst_ready", {31'b0, req_ready}, 32'd1);
    quiet_window("rd0_rst", wr_base, 0);
    check_eq("rd0_rst_mem", mem[5], 32'h11991234);

    run_req("post_rst_lw", 1'b0, 3'b010, 32'h14, 32'h0, 32'h11991234, 1'b0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
